bin2bcd_seg6: RTL and testbench

Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that feeds the 6-digit multiplexed seven-segment scanner. Converts an unsigned binary count into six packed BCD digits, one digit per scanned position. The digits are held stable between conversions so the scanner can read them at any time. Upstream logic (counters, sensors) issues a start pulse; the scanner consumes BCD_OUT directly.

---
 rtl/bin2bcd_seg6.sv | 209 ++++++++++++++++++++
 tb/tb_bin2bcd_seg6.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seg6.sv
// -----------------------------------------------------------------------------
// bin2bcd_seg6
//
// Sequential binary-to-BCD converter (shift-add-3 / double-dabble) feeding the
// 6-digit multiplexed seven-segment scanner. An unsigned binary value is
// converted into six packed BCD digits, one per scanned position. The digit
// register only changes on the completion cycle, so the scanner may read
// BCD_OUT at any time without ever seeing a partially converted value.
//
// Parameters:
//   BIN_W    width of BIN_IN, legal range 4..20
//   MAX_VAL  largest displayable value; larger inputs are clamped to it
//
// Ports:
//   CLK_50M  in   1      system clock (50 MHz)
//   RST_N    in   1      asynchronous active-low reset
//   START    in   1      conversion request, accepted only while idle
//   BIN_IN   in   BIN_W  unsigned operand, sampled when START is accepted
//   BUSY     out  1      high while a conversion is in flight (state != IDLE)
//   DONE     out  1      one-cycle pulse coinciding with the BCD_OUT/OVF update
//   OVF      out  1      last accepted operand exceeded MAX_VAL
//   BCD_OUT  out  24     packed digits, [3:0] = units ... [23:20] = 10^5
//
// Optional feature (macro LEADING_ZERO_BLANK_EN):
//   When defined, leading zero digits from 10^5 down to 10^1 are replaced by
//   4'hF (the scanner decoder's blank code) as the result is registered. The
//   units digit is never blanked. When undefined all digits stay numeric.
//
// Timing: START accepted at edge N, iterations at edges N+1..N+BIN_W, result
// registered and DONE asserted at edge N+BIN_W+1. BUSY covers BIN_W+1 cycles.
// -----------------------------------------------------------------------------
module bin2bcd_seg6 #(
  parameter int BIN_W   = 20,
  parameter int MAX_VAL = 999999
) (
  input  logic             CLK_50M,
  input  logic             RST_N,
  input  logic             START,
  input  logic [BIN_W-1:0] BIN_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVF,
  output logic [23:0]      BCD_OUT
);

  // Operand field is always 20 bits wide; narrower inputs are left-aligned in
  // it so that exactly BIN_W shifts move every operand bit into the BCD field.
  localparam int OP_W  = 20;
  localparam int BCD_W = 24;
  localparam int SR_W  = BCD_W + OP_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  localparam logic [OP_W-1:0]  MAX_VAL_C = OP_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [SR_W-1:0]   shift_reg, shift_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [BCD_W-1:0]  bcd_reg, bcd_next;
  logic              ovf_reg, ovf_next;
  // Overflow flag of the conversion in flight; only committed to OVF on the
  // completion edge so OVF and BCD_OUT always describe the same operand.
  logic              ovf_pend_reg, ovf_pend_next;
  logic              done_reg, done_next;

  // ---------------------------------------------------------------------------
  // Operand load: zero-extend, clamp against MAX_VAL, left-align.
  // ---------------------------------------------------------------------------
  logic [OP_W-1:0] bin_ext;
  logic            op_over;
  logic [OP_W-1:0] op_sel;
  logic [OP_W-1:0] op_aligned;

  assign bin_ext    = OP_W'(BIN_IN);
  assign op_over    = (bin_ext > MAX_VAL_C);
  assign op_sel     = op_over ? MAX_VAL_C : bin_ext;
  // op_sel never exceeds BIN_W bits (either BIN_IN itself or a clamp value
  // smaller than BIN_IN), so no significant bits are lost by this shift.
  assign op_aligned = op_sel << (OP_W - BIN_W);

  // ---------------------------------------------------------------------------
  // One double-dabble iteration: add 3 to every nibble >= 5, then shift left.
  // The operand MSB (bit OP_W-1) lands in BCD bit 0 via the shift.
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] bcd_adj;
  logic [SR_W-1:0]  iter_value;
  logic [SR_W-1:0]  iter_shifted;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = shift_reg[OP_W + 4*gi +: 4];
      // A nibble is at most 9 before correction, so the sum tops out at 4'hC.
      assign bcd_adj[4*gi +: 4] = (nib >= 4'd5) ? (nib + 4'd3) : nib;
    end
  endgenerate

  assign iter_value   = {bcd_adj, shift_reg[OP_W-1:0]};
  assign iter_shifted = iter_value << 1;

  // ---------------------------------------------------------------------------
  // Result formatting (optionally blanking leading zeros).
  // ---------------------------------------------------------------------------
  logic [BCD_W-1:0] bcd_result;
  logic [BCD_W-1:0] bcd_display;

  assign bcd_result = shift_reg[SR_W-1:OP_W];

`ifdef LEADING_ZERO_BLANK_EN
  // lead_zero[k] is set when digit k and every digit above it are zero.
  // Index 0 is tied low: the units digit always shows, so 0 reads as "0".
  logic [5:0] lead_zero;

  assign lead_zero[5] = (bcd_result[23:20] == 4'd0);
  assign lead_zero[0] = 1'b0;

  generate
    for (gi = 1; gi < 5; gi++) begin : g_lead
      assign lead_zero[gi] = lead_zero[gi+1] && (bcd_result[4*gi +: 4] == 4'd0);
    end
    for (gi = 0; gi < 6; gi++) begin : g_blank
      assign bcd_display[4*gi +: 4] = lead_zero[gi] ? 4'hF : bcd_result[4*gi +: 4];
    end
  endgenerate
`else
  assign bcd_display = bcd_result;
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      bcd_reg      <= '0;
      ovf_reg      <= 1'b0;
      ovf_pend_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      cnt_reg      <= cnt_next;
      bcd_reg      <= bcd_next;
      ovf_reg      <= ovf_next;
      ovf_pend_reg <= ovf_pend_next;
      done_reg     <= done_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / datapath control
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    cnt_next      = cnt_reg;
    bcd_next      = bcd_reg;
    ovf_next      = ovf_reg;
    ovf_pend_next = ovf_pend_reg;
    done_next     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (START) begin
          shift_next    = {{BCD_W{1'b0}}, op_aligned};
          ovf_pend_next = op_over;
          cnt_next      = '0;
          state_next    = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shift_next = iter_shifted;
        cnt_next   = cnt_reg + 1'b1;
        if (cnt_reg == LAST_ITER) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        // START is deliberately not looked at here; the next request can only
        // be accepted from IDLE on the following edge.
        bcd_next   = bcd_display;
        ovf_next   = ovf_pend_reg;
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign BUSY    = (state_reg != ST_IDLE);
  assign DONE    = done_reg;
  assign OVF     = ovf_reg;
  assign BCD_OUT = bcd_reg;

endmodule

// File: tb/tb_bin2bcd_seg6.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_seg6
//
// Scoreboard bench for bin2bcd_seg6. A reference process watches START at each
// rising edge, decides acceptance from its own busy window, and pushes the
// expected digits (decimal arithmetic), overflow flag and due edge into a
// queue. A monitor on the falling edge pops an entry whenever DONE is seen and
// also checks that BUSY/BCD_OUT/OVF behave between completions.
// -----------------------------------------------------------------------------
module tb_bin2bcd_seg6;

  localparam int BW   = 20;
  localparam int MAXV = 999999;

  logic          CLK_50M;
  logic          RST_N;
  logic          START;
  logic [BW-1:0] BIN_IN;
  logic          BUSY;
  logic          DONE;
  logic          OVF;
  logic [23:0]   BCD_OUT;

  bin2bcd_seg6 #(
    .BIN_W   (BW),
    .MAX_VAL (MAXV)
  ) dut (
    .CLK_50M (CLK_50M),
    .RST_N   (RST_N),
    .START   (START),
    .BIN_IN  (BIN_IN),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVF     (OVF),
    .BCD_OUT (BCD_OUT)
  );

  initial begin
    CLK_50M = 1'b0;
    forever #10 CLK_50M = ~CLK_50M;
  end

  typedef struct {
    logic [23:0] bcd;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  int edge_cnt   = 0;
  int acc_edge   = 0;
  bit acc_valid  = 1'b0;
  bit model_busy = 1'b0;

  logic [23:0] hold_bcd = 24'h0;
  logic        hold_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Decimal digits of v, written straight from the positional definition.
  function automatic logic [23:0] ref_digits(input int v);
    logic [23:0] r;
    int          x;
    bit          leading;
    r = '0;
    x = v;
    for (int k = 0; k < 6; k++) begin
      r[k*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef LEADING_ZERO_BLANK_EN
    leading = 1'b1;
    for (int k = 5; k >= 1; k--) begin
      if (leading && r[k*4 +: 4] == 4'd0) r[k*4 +: 4] = 4'hF;
      else leading = 1'b0;
    end
`else
    leading = 1'b0;
`endif
    return r;
  endfunction

  // Reference: acceptance, expected result and busy window.
  initial begin
    int   v;
    exp_t e;
    forever begin
      @(posedge CLK_50M);
      edge_cnt++;
      if (!RST_N) begin
        acc_valid  = 1'b0;
        model_busy = 1'b0;
      end else begin
        if (START && (!acc_valid || edge_cnt >= acc_edge + BW + 2)) begin
          acc_edge  = edge_cnt;
          acc_valid = 1'b1;
          v         = int'(BIN_IN);
          e.ovf     = (v > MAXV);
          e.bcd     = ref_digits(e.ovf ? MAXV : v);
          e.due     = edge_cnt + BW + 1;
          sb_q.push_back(e);
          $display("issue  edge %0d: BIN_IN=%0d expect %h ovf=%0d", edge_cnt, v, e.bcd, e.ovf);
        end
        model_busy = acc_valid && (edge_cnt <= acc_edge + BW);
      end
    end
  end

  // Monitor: compares on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK_50M);
      if (!RST_N) begin
        sb_q.delete();
        hold_bcd = 24'h0;
        hold_ovf = 1'b0;
        chk("rst_busy", {31'd0, BUSY}, 32'd0);
        chk("rst_done", {31'd0, DONE}, 32'd0);
        chk("rst_bcd",  {8'd0, BCD_OUT}, 32'd0);
        chk("rst_ovf",  {31'd0, OVF}, 32'd0);
      end else begin
        if (DONE) begin
          if (sb_q.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
          end else begin
            e = sb_q.pop_front();
            chk("done_edge", edge_cnt, e.due);
            chk("bcd_out",   {8'd0, BCD_OUT}, {8'd0, e.bcd});
            chk("ovf",       {31'd0, OVF}, {31'd0, e.ovf});
            $display("result edge %0d: BCD_OUT=%h OVF=%0d", edge_cnt, BCD_OUT, OVF);
            hold_bcd = e.bcd;
            hold_ovf = e.ovf;
          end
        end else begin
          if (sb_q.size() != 0 && sb_q[0].due <= edge_cnt) begin
            e = sb_q.pop_front();
            chk("missing_done", 32'd0, 32'd1);
            hold_bcd = e.bcd;
            hold_ovf = e.ovf;
          end
          chk("bcd_hold", {8'd0, BCD_OUT}, {8'd0, hold_bcd});
          chk("ovf_hold", {31'd0, OVF}, {31'd0, hold_ovf});
        end
        chk("busy", {31'd0, BUSY}, {31'd0, model_busy});
      end
    end
  end

  task automatic convert(input int v);
    @(posedge CLK_50M);
    #1;
    START  = 1'b1;
    BIN_IN = BW'(v);
    @(posedge CLK_50M);
    #1;
    START  = 1'b0;
    BIN_IN = BW'($urandom);
    repeat (BW + 3) @(posedge CLK_50M);
  endtask

  // Stimulus
  initial begin
    RST_N  = 1'b0;
    START  = 1'b0;
    BIN_IN = '0;
    repeat (3) @(posedge CLK_50M);
    #1 RST_N = 1'b1;
    repeat (2) @(posedge CLK_50M);

    convert(0);
    convert(123456);
    convert(1048575);
    convert(999999);
    convert(705);
    convert(100000);
    convert(10);

    // START held high: accepted only from IDLE, operand change mid-run ignored.
    @(posedge CLK_50M);
    #1;
    START  = 1'b1;
    BIN_IN = BW'(42);
    repeat (5) @(posedge CLK_50M);
    #1 BIN_IN = BW'(77);
    repeat (65) @(posedge CLK_50M);
    #1 START = 1'b0;
    repeat (BW + 5) @(posedge CLK_50M);

    // Reset in the middle of a conversion.
    @(posedge CLK_50M);
    #1;
    START  = 1'b1;
    BIN_IN = BW'(500000);
    @(posedge CLK_50M);
    #1 START = 1'b0;
    repeat (10) @(posedge CLK_50M);
    #3 RST_N = 1'b0;
    #1;
    chk("async_busy", {31'd0, BUSY}, 32'd0);
    chk("async_bcd",  {8'd0, BCD_OUT}, 32'd0);
    chk("async_ovf",  {31'd0, OVF}, 32'd0);
    chk("async_done", {31'd0, DONE}, 32'd0);
    repeat (2) @(posedge CLK_50M);
    #1 RST_N = 1'b1;
    repeat (BW + 5) @(posedge CLK_50M);
    convert(7);

    // Random traffic, including requests that arrive while busy.
    for (int i = 0; i < 800; i++) begin
      @(posedge CLK_50M);
      #1;
      START = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       BIN_IN = BW'($urandom_range(0, 999));
        1:       BIN_IN = BW'($urandom_range(999000, 1048575));
        default: BIN_IN = BW'($urandom_range(0, 1048575));
      endcase
    end
    #1 START = 1'b0;
    repeat (BW + 8) @(posedge CLK_50M);

    chk("queue_drained", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
